// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI-slave register file on the system clock.
// SPI pins are oversampled; frames are R/W flag, address (MSB first), then
// DATA_W-bit words with burst auto-increment. A local parallel port shares
// the array, and SPI commits win over local writes to the same address.
module spi_slave_regs #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 20,
  parameter int unsigned TA     = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_ss,
  input  logic              spi_sclk,
  inout  wire               spi_sda,
  input  logic              loc_wr_en,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              spi_wr_pulse,
  output logic [ADDR_W-1:0] spi_wr_addr,
  output logic              frame_err
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned MAX_AD  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int unsigned CNT_MAX = (MAX_AD > TA) ? MAX_AD : TA;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RTA,
    ST_RDATA
  } state_e;

  state_e state_q, state_d;

  // Synchroniser chains; the third flop on ss/sclk provides edge detection.
  logic [2:0] ss_sync_q;
  logic [2:0] sclk_sync_q;
  logic [1:0] sda_sync_q;

  logic ss_rise, ss_fall, sclk_rise, sclk_fall, sda_in;

  // Frame datapath
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wsr_q, wsr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              out_en_q, out_en_d;
  logic              rd_next_q, rd_next_d;
  logic              boundary_q, boundary_d;
  logic              commit_q, commit_d;
  logic [ADDR_W-1:0] commit_addr_q, commit_addr_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;
  logic              frame_err_q, frame_err_d;

  // Register array and local read port
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] loc_rdata_q;

  logic              addr_last, ta_last, word_last;
  logic [ADDR_W-1:0] addr_shift, addr_inc;
  logic [DATA_W-1:0] wsr_shift;

  // Two-flop synchronisers plus one edge-detect flop on ss and sclk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      sda_sync_q  <= '0;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], spi_ss};
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
      sda_sync_q  <= {sda_sync_q[0], spi_sda};
    end
  end

  assign ss_rise   =  ss_sync_q[1]   & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1]   &  ss_sync_q[2];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign sda_in    =  sda_sync_q[1];

  assign addr_last  = (cnt_q == CNT_W'(ADDR_W - 1));
  assign ta_last    = (cnt_q == CNT_W'(TA - 1));
  assign word_last  = (cnt_q == CNT_W'(DATA_W - 1));
  assign addr_shift = ADDR_W'({addr_q, sda_in});
  assign addr_inc   = addr_q + ADDR_W'(1);
  assign wsr_shift  = DATA_W'({wsr_q, sda_in});

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a detected ss fall overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (ss_fall) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (ss_rise)                state_d = ST_CMD;
        ST_CMD:   if (sclk_rise)              state_d = ST_ADDR;
        ST_ADDR:  if (sclk_rise && addr_last) state_d = rw_q ? ST_RTA : ST_WDATA;
        ST_RTA:   if (sclk_rise && ta_last)   state_d = ST_RDATA;
        ST_WDATA: state_d = ST_WDATA;
        ST_RDATA: state_d = ST_RDATA;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: per-state datapath updates on detected sclk/ss edges.
  always_comb begin
    cnt_d         = cnt_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wsr_d         = wsr_q;
    tx_d          = tx_q;
    out_en_d      = out_en_q;
    rd_next_d     = rd_next_q;
    boundary_d    = boundary_q;
    commit_d      = 1'b0;
    commit_addr_d = commit_addr_q;
    commit_data_d = commit_data_q;
    frame_err_d   = 1'b0;
    if (ss_fall) begin
      // boundary_q is only ever set inside a data state on a word's last bit
      frame_err_d = (state_q != ST_IDLE) && !boundary_q;
      cnt_d       = '0;
      out_en_d    = 1'b0;
      rd_next_d   = 1'b0;
      boundary_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ss_rise) begin
            cnt_d      = '0;
            rd_next_d  = 1'b0;
            boundary_d = 1'b0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            rw_d  = sda_in;
            cnt_d = '0;
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr_d = addr_shift;
            if (addr_last) begin
              cnt_d = '0;
              if (rw_q) tx_d = mem_q[addr_shift];
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RTA: begin
          if (sclk_rise) begin
            cnt_d = ta_last ? '0 : cnt_q + CNT_W'(1);
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            wsr_d = wsr_shift;
            if (word_last) begin
              cnt_d         = '0;
              commit_d      = 1'b1;
              commit_addr_d = addr_q;
              commit_data_d = wsr_shift;
              addr_d        = addr_inc;
              boundary_d    = 1'b1;
            end else begin
              cnt_d      = cnt_q + CNT_W'(1);
              boundary_d = 1'b0;
            end
          end
        end
        ST_RDATA: begin
          if (sclk_rise) begin
            if (word_last) begin
              cnt_d      = '0;
              rd_next_d  = 1'b1;
              boundary_d = 1'b1;
            end else begin
              cnt_d      = cnt_q + CNT_W'(1);
              boundary_d = 1'b0;
            end
          end else if (sclk_fall) begin
            // First fall enables the driver on the snapshot MSB; a fall after
            // a complete word fetches the next word with no turnaround.
            if (!out_en_q) begin
              out_en_d = 1'b1;
            end else if (rd_next_q) begin
              addr_d    = addr_inc;
              tx_d      = mem_q[addr_inc];
              rd_next_d = 1'b0;
            end else begin
              tx_d = {tx_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  // Frame datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q         <= '0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      wsr_q         <= '0;
      tx_q          <= '0;
      out_en_q      <= 1'b0;
      rd_next_q     <= 1'b0;
      boundary_q    <= 1'b0;
      commit_q      <= 1'b0;
      commit_addr_q <= '0;
      commit_data_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      wsr_q         <= wsr_d;
      tx_q          <= tx_d;
      out_en_q      <= out_en_d;
      rd_next_q     <= rd_next_d;
      boundary_q    <= boundary_d;
      commit_q      <= commit_d;
      commit_addr_q <= commit_addr_d;
      commit_data_q <= commit_data_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Register array: local write first so a same-address SPI commit wins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mem_q       <= '{default: '0};
      loc_rdata_q <= '0;
    end else begin
      if (loc_wr_en) mem_q[loc_addr] <= loc_wdata;
      if (commit_q)  mem_q[commit_addr_q] <= commit_data_q;
      loc_rdata_q <= mem_q[loc_addr];
    end
  end

  assign spi_sda      = out_en_q ? tx_q[DATA_W-1] : 1'bz;
  assign loc_rdata    = loc_rdata_q;
  assign spi_wr_pulse = commit_q;
  assign spi_wr_addr  = commit_addr_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: table of single-word transactions
// plus hand-written burst, abort, collision and reset sequences. SPI commits
// are tracked by a scoreboard queue popped on each spi_wr_pulse.
module tb_spi_slave_regs;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 20;
  localparam int unsigned TAB  = 1;
  localparam int          HALF = 5;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          ss        = 1'b0;
  logic          sclk      = 1'b0;
  logic          loc_wr_en = 1'b0;
  logic [AW-1:0] loc_addr  = '0;
  logic [DW-1:0] loc_wdata = '0;
  logic          m_oe      = 1'b0;
  logic          m_bit     = 1'b0;
  wire  [DW-1:0] loc_rdata;
  wire           wr_pulse;
  wire  [AW-1:0] wr_addr;
  wire           ferr;
  wire           sda;

  assign sda = m_oe ? m_bit : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  spi_slave_regs #(.ADDR_W(AW), .DATA_W(DW), .TA(TAB)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .spi_ss       (ss),
    .spi_sclk     (sclk),
    .spi_sda      (sda),
    .loc_wr_en    (loc_wr_en),
    .loc_addr     (loc_addr),
    .loc_wdata    (loc_wdata),
    .loc_rdata    (loc_rdata),
    .spi_wr_pulse (wr_pulse),
    .spi_wr_addr  (wr_addr),
    .frame_err    (ferr)
  );

  int n_chk   = 0;
  int n_pass  = 0;
  int n_ferr  = 0;
  int n_pulse = 0;
  int exp_ferr  = 0;
  int exp_pulse = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t wr_q[$];
  wr_t mon_e;

  logic [DW-1:0] wbuf [4];
  logic [DW-1:0] rbuf [4];

  typedef struct {
    int            kind;  // 0 loc write, 1 loc read, 2 spi write, 3 spi read
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard and pulse counters, sampled on the falling sys_clk edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr) n_ferr++;
      if (wr_pulse) begin
        n_pulse++;
        if (wr_q.size() > 0) begin
          mon_e = wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        end
      end
    end
  end

  task automatic spi_bit(input logic drive, input logic b, output logic rb);
    m_oe  = drive;
    m_bit = b;
    tick(HALF);
    rb   = sda;
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic ss_begin();
    ss = 1'b1;
    tick(6);
  endtask

  task automatic ss_end();
    m_oe = 1'b0;
    tick(3);
    ss = 1'b0;
    tick(8);
  endtask

  task automatic spi_frame(input logic rw, input logic [AW-1:0] a, input int nbits);
    logic rb;
    int   w;
    ss_begin();
    spi_bit(1'b1, rw, rb);
    for (int i = AW - 1; i >= 0; i--) spi_bit(1'b1, a[i], rb);
    if (rw) begin
      for (int t = 0; t < int'(TAB); t++) begin
        spi_bit(1'b0, 1'b0, rb);
        check("ta_hiz", 32'(rb), 32'd1);
      end
    end
    for (int k = 0; k < nbits; k++) begin
      w = k / int'(DW);
      if (rw) begin
        spi_bit(1'b0, 1'b0, rb);
        rbuf[w] = {rbuf[w][DW-2:0], rb};
      end else begin
        if (k % int'(DW) == int'(DW) - 1) begin
          wr_q.push_back({AW'(int'(a) + w), wbuf[w]});
          exp_pulse++;
        end
        spi_bit(1'b1, wbuf[w][int'(DW) - 1 - (k % int'(DW))], rb);
      end
    end
    ss_end();
  endtask

  task automatic loc_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    loc_addr  = a;
    loc_wdata = d;
    loc_wr_en = 1'b1;
    tick(1);
    loc_wr_en = 1'b0;
  endtask

  task automatic loc_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    loc_addr = a;
    tick(2);
    check(name, 32'(loc_rdata), 32'(exp));
  endtask

  task automatic frame_status(input string name);
    check({name, "_pulses"}, 32'(n_pulse), 32'(exp_pulse));
    check({name, "_ferr"}, 32'(n_ferr), 32'(exp_ferr));
  endtask

  initial begin
    logic rb;
    int   n;

    vt[0] = '{kind: 2, addr: 4'h3, data: 20'hA5A5A};
    vt[1] = '{kind: 1, addr: 4'h3, data: 20'hA5A5A};
    vt[2] = '{kind: 0, addr: 4'h7, data: 20'h12345};
    vt[3] = '{kind: 3, addr: 4'h7, data: 20'h12345};
    vt[4] = '{kind: 0, addr: 4'h5, data: 20'h55555};
    vt[5] = '{kind: 1, addr: 4'h5, data: 20'h55555};
    vt[6] = '{kind: 2, addr: 4'h9, data: 20'h0F00F};
    vt[7] = '{kind: 1, addr: 4'h9, data: 20'h0F00F};
    vt[8] = '{kind: 3, addr: 4'h3, data: 20'hA5A5A};
    vt[9] = '{kind: 1, addr: 4'h0, data: 20'h00000};

    // Reset state
    tick(3);
    check("rst_sda_hiz",   32'(sda),       32'd1);
    check("rst_loc_rdata", 32'(loc_rdata), 32'd0);
    check("rst_wr_pulse",  32'(wr_pulse),  32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_frame_err", 32'(ferr),      32'd0);
    rst_n = 1'b1;
    tick(2);
    loc_check("rst_mem3", 4'h3, 20'h0);

    // Single-word vectors
    for (int v = 0; v < 10; v++) begin
      case (vt[v].kind)
        0: loc_write(vt[v].addr, vt[v].data);
        1: loc_check("vec_loc_rd", vt[v].addr, vt[v].data);
        2: begin
          wbuf[0] = vt[v].data;
          spi_frame(1'b0, vt[v].addr, int'(DW));
          frame_status("vec_wr");
        end
        default: begin
          spi_frame(1'b1, vt[v].addr, int'(DW));
          check("vec_spi_rd", 32'(rbuf[0]), 32'(vt[v].data));
          check("vec_sda_released", 32'(sda), 32'd1);
          frame_status("vec_rd");
        end
      endcase
    end

    // Burst write wrapping past the top address
    wbuf[0] = 20'h00001;
    wbuf[1] = 20'h00002;
    wbuf[2] = 20'h00003;
    spi_frame(1'b0, 4'hF, 3 * int'(DW));
    frame_status("burst_wr");
    loc_check("burst_mF", 4'hF, 20'h00001);
    loc_check("burst_m0", 4'h0, 20'h00002);
    loc_check("burst_m1", 4'h1, 20'h00003);

    // Burst read across E -> F with no gap bits
    loc_write(4'hE, 20'hABCDE);
    spi_frame(1'b1, 4'hE, 2 * int'(DW));
    check("burst_rd_w0", 32'(rbuf[0]), 32'h000ABCDE);
    check("burst_rd_w1", 32'(rbuf[1]), 32'h00000001);
    frame_status("burst_rd");

    // Write aborted after 10 data bits
    wbuf[0] = 20'hFFFFF;
    spi_frame(1'b0, 4'h5, 10);
    exp_ferr++;
    frame_status("abort_wr");
    loc_check("abort_m5", 4'h5, 20'h55555);

    // Frame closed after only the command bit
    ss_begin();
    spi_bit(1'b1, 1'b0, rb);
    ss_end();
    exp_ferr++;
    frame_status("abort_cmd");

    // Same-cycle SPI commit and local write to address 2
    loc_addr = 4'h2;
    wbuf[0]  = 20'h7C3E1;
    ss_begin();
    spi_bit(1'b1, 1'b0, rb);
    for (int i = AW - 1; i >= 0; i--) spi_bit(1'b1, loc_addr[i], rb);
    for (int k = 0; k < int'(DW) - 1; k++) spi_bit(1'b1, wbuf[0][int'(DW) - 1 - k], rb);
    m_oe  = 1'b1;
    m_bit = wbuf[0][0];
    tick(HALF);
    wr_q.push_back({4'h2, wbuf[0]});
    exp_pulse++;
    sclk = 1'b1;
    n = 0;
    while (!wr_pulse && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("coll_pulse_seen", 32'(wr_pulse), 32'd1);
    loc_wdata = 20'hDEAD0;
    loc_wr_en = 1'b1;
    @(posedge clk);
    #1;
    loc_wr_en = 1'b0;
    check("coll_old_value", 32'(loc_rdata), 32'h0);
    @(posedge clk);
    #1;
    check("coll_spi_wins", 32'(loc_rdata), 32'h0007C3E1);
    tick(HALF - 3);
    sclk = 1'b0;
    ss_end();
    frame_status("coll");
    check("coll_wr_addr", 32'(wr_addr), 32'h2);

    // Reset pulsed while the slave drives read data (MSB of 12345 is 0)
    ss_begin();
    spi_bit(1'b1, 1'b1, rb);
    for (int i = AW - 1; i >= 0; i--) spi_bit(1'b1, AW'(7) >> i, rb);
    spi_bit(1'b0, 1'b0, rb);
    m_oe = 1'b0;
    tick(HALF);
    check("rd_driving_msb", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstmid_sda_hiz",   32'(sda),       32'd1);
    check("rstmid_loc_rdata", 32'(loc_rdata), 32'd0);
    check("rstmid_wr_addr",   32'(wr_addr),   32'd0);
    check("rstmid_wr_pulse",  32'(wr_pulse),  32'd0);
    check("rstmid_frame_err", 32'(ferr),      32'd0);
    ss = 1'b0;
    tick(3);
    rst_n = 1'b1;
    loc_check("rstmid_mem7", 4'h7, 20'h0);
    tick(10);
    frame_status("rstmid");
    check("scoreboard_empty", 32'(wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
